// File: rtl/game_pkg.sv
// Shared game datapath definitions.
// Sequencer state encoding and default unit/timeout constants.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } seq_state_e;

  localparam int NUM_UNITS_DEF = 4;
  localparam int TIMEOUT_DEF   = 1023;
  localparam int CNT_W_DEF     = 10;

endpackage

// File: rtl/unit_watchdog.sv
// Per-unit watchdog: load/decrement down-counter.
// Raises zero when the count has run out.
module unit_watchdog #(
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic clock,
  input  logic reset,
  input  logic load,
  input  logic dec,
  output logic zero
);

  logic [CNT_W-1:0] count;

  // load wins over decrement; hold when neither
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(TIMEOUT);
    end else if (dec && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame scheduler: starts units one at a time on vsync.
// Counts frames, flags overruns and hung units.
module frame_sequencer
  import game_pkg::*;
#(
  parameter int NUM_UNITS = NUM_UNITS_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 vsync,
  input  logic                 enable,
  input  logic [NUM_UNITS-1:0] done,
  input  logic                 clear_errors,
  output logic [NUM_UNITS-1:0] start,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic                 overrun,
  output logic [NUM_UNITS-1:0] timeout_err
);

  localparam int IDX_W =
    (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
  localparam logic [IDX_W-1:0] LAST =
    IDX_W'(NUM_UNITS - 1);

  seq_state_e       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vsync_d;
  logic             frame_edge;
  logic             wd_load, wd_dec, wd_zero;
  logic             advance, expire, frame_inc;

  assign frame_edge = vsync_d & ~vsync;

  unit_watchdog #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clock (clock),
    .reset (reset),
    .load  (wd_load),
    .dec   (wd_dec),
    .zero  (wd_zero)
  );

  // state, active unit and vsync history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      vsync_d <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_d <= vsync;
    end
  end

  // next state; a timeout advances exactly like done
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wd_load   = 1'b0;
    wd_dec    = 1'b0;
    advance   = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (frame_edge && enable) begin
          idx_d   = '0;
          state_d = START;
        end
      end
      START: begin
        wd_load = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (done[idx_q]) begin
          advance = 1'b1;
        end else if (wd_zero) begin
          advance = 1'b1;
          expire  = 1'b1;
        end else begin
          wd_dec = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (advance) begin
      if (idx_q == LAST) begin
        state_d = IDLE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = START;
      end
    end
    frame_inc = advance && (idx_q == LAST);
  end

  // one-hot start straight from registered state
  always_comb begin
    start = '0;
    if (state_q == START) start[idx_q] = 1'b1;
  end

  assign busy = (state_q != IDLE);

  // completed-sequence counter, wraps naturally
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
    end else if (frame_inc) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  // sticky flags; a set in the clearing cycle wins
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun     <= 1'b0;
      timeout_err <= '0;
    end else begin
      if (clear_errors) begin
        overrun     <= 1'b0;
        timeout_err <= '0;
      end
      if (frame_edge && state_q != IDLE) overrun <= 1'b1;
      if (expire) timeout_err[idx_q] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: queued expected events,
// monitor pops on every start pulse and busy fall.
module tb_frame_sequencer;

  localparam int NU = 4;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          vsync = 1'b1;
  logic          enable = 1'b1;
  logic          clear_errors = 1'b0;
  logic [NU-1:0] done = '0;
  logic [NU-1:0] start;
  logic          busy;
  logic [15:0]   frame_count;
  logic          overrun;
  logic [NU-1:0] timeout_err;

  frame_sequencer #(
    .NUM_UNITS (NU),
    .TIMEOUT   (TO),
    .CNT_W     (CW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .vsync        (vsync),
    .enable       (enable),
    .done         (done),
    .clear_errors (clear_errors),
    .start        (start),
    .busy         (busy),
    .frame_count  (frame_count),
    .overrun      (overrun),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit          is_end;
    int          at;
    logic [3:0]  st;
    logic [15:0] fc;
    logic [3:0]  te;
    logic        ov;
  } ev_t;

  ev_t exp_q[$];

  logic [NU-1:0] mute = '0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h want %h",
               name, cyc, act, req);
    end
  endtask

  task automatic push(input bit k, input int at,
                      input logic [3:0] st,
                      input logic [15:0] fc,
                      input logic [3:0] te,
                      input logic ov);
    ev_t e;
    e.is_end = k;
    e.at = at;
    e.st = st;
    e.fc = fc;
    e.te = te;
    e.ov = ov;
    exp_q.push_back(e);
  endtask

  // a fault-free four-unit sequence from an edge in cycle e
  task automatic push_plain(input int e,
                            input logic [15:0] fc0,
                            input logic [15:0] fc1);
    push(0, e + 1,  4'b0001, fc0, 4'b0000, 1'b0);
    push(0, e + 5,  4'b0010, fc0, 4'b0000, 1'b0);
    push(0, e + 9,  4'b0100, fc0, 4'b0000, 1'b0);
    push(0, e + 13, 4'b1000, fc0, 4'b0000, 1'b0);
    push(1, e + 17, 4'b0000, fc1, 4'b0000, 1'b0);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic frame_edge();
    vsync = 1'b0;
    wait_cyc(2);
    vsync = 1'b1;
  endtask

  task automatic pulse_clear();
    clear_errors = 1'b1;
    wait_cyc(1);
    clear_errors = 1'b0;
  endtask

  task automatic observe(input bit k);
    ev_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event at cycle %0d: kind %0d start %b",
               cyc, k, start);
    end else begin
      e = exp_q.pop_front();
      chk(k ? "seq_end" : "start_pulse",
          {k, cyc[15:0], start, frame_count, timeout_err, overrun},
          {e.is_end, e.at[15:0], e.st, e.fc, e.te, e.ov});
    end
  endtask

  // unit model: answer done 3 cycles after start unless muted
  initial begin
    logic [NU-1:0] pend;
    int dly;
    pend = '0;
    dly = 0;
    forever begin
      @(posedge clock);
      #1;
      done = '0;
      if (reset) begin
        dly = 0;
        pend = '0;
      end else begin
        if (dly > 0) begin
          dly--;
          if (dly == 0) done = pend;
        end
        if ((start & ~mute) != '0) begin
          pend = start;
          dly = 3;
        end
      end
    end
  end

  // monitor: sample mid-cycle, compare against the queue
  initial begin
    bit pb;
    pb = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pb = 1'b0;
      end else begin
        if (start != '0) observe(1'b0);
        if (pb && !busy) observe(1'b1);
        pb = busy;
      end
    end
  end

  initial begin
    int e;
    wait_cyc(3);
    reset = 1'b0;

    for (int i = 0; i < 100; i++) begin
      wait_cyc(1);
      chk("idle_after_reset",
          {start, busy, frame_count}, 64'd0);
    end

    // plain sequence
    e = cyc;
    push_plain(e, 16'd0, 16'd1);
    frame_edge();
    wait_cyc(20);

    // unit 2 hangs, watchdog forces it
    mute = 4'b0100;
    e = cyc;
    push(0, e + 1,  4'b0001, 16'd1, 4'b0000, 1'b0);
    push(0, e + 5,  4'b0010, 16'd1, 4'b0000, 1'b0);
    push(0, e + 9,  4'b0100, 16'd1, 4'b0000, 1'b0);
    push(0, e + 19, 4'b1000, 16'd1, 4'b0100, 1'b0);
    push(1, e + 23, 4'b0000, 16'd2, 4'b0100, 1'b0);
    frame_edge();
    wait_cyc(26);
    mute = '0;
    chk("timeout_sticky", timeout_err, 64'h4);
    pulse_clear();
    chk("timeout_cleared", timeout_err, 64'h0);

    // second edge while unit 1 waits
    e = cyc;
    push(0, e + 1,  4'b0001, 16'd2, 4'b0000, 1'b0);
    push(0, e + 5,  4'b0010, 16'd2, 4'b0000, 1'b0);
    push(0, e + 9,  4'b0100, 16'd2, 4'b0000, 1'b1);
    push(0, e + 13, 4'b1000, 16'd2, 4'b0000, 1'b1);
    push(1, e + 17, 4'b0000, 16'd3, 4'b0000, 1'b1);
    frame_edge();
    wait_cyc(5);
    frame_edge();
    wait_cyc(14);
    chk("overrun_sticky", overrun, 64'd1);
    pulse_clear();
    chk("overrun_cleared", overrun, 64'd0);

    // paused: edge ignored
    enable = 1'b0;
    frame_edge();
    wait_cyc(15);
    chk("paused_no_seq", {busy, frame_count}, 64'd3);

    // enable dropped during unit 1
    enable = 1'b1;
    e = cyc;
    push_plain(e, 16'd3, 16'd4);
    frame_edge();
    wait_cyc(3);
    enable = 1'b0;
    wait_cyc(17);
    enable = 1'b1;

    // frame counter wrap
    force dut.frame_count = 16'hFFFF;
    wait_cyc(2);
    release dut.frame_count;
    wait_cyc(1);
    chk("preload", frame_count, 64'hFFFF);
    e = cyc;
    push_plain(e, 16'hFFFF, 16'h0000);
    frame_edge();
    wait_cyc(20);

    // reset while unit 2 waits
    e = cyc;
    push(0, e + 1, 4'b0001, 16'd0, 4'b0000, 1'b0);
    push(0, e + 5, 4'b0010, 16'd0, 4'b0000, 1'b0);
    push(0, e + 9, 4'b0100, 16'd0, 4'b0000, 1'b0);
    frame_edge();
    wait_cyc(8);
    reset = 1'b1;
    #1;
    chk("reset_mid_seq",
        {start, busy, frame_count, overrun, timeout_err},
        64'd0);
    wait_cyc(2);
    reset = 1'b0;
    wait_cyc(3);
    e = cyc;
    push_plain(e, 16'd0, 16'd1);
    frame_edge();
    wait_cyc(20);

    chk("all_events_seen", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
